// File: rtl/fp_div_seq.sv
// ---------------------------------------------------------------------------
// fp_div_seq -- sequential IEEE-754 style floating point divider
//
// Computes c = a / b one quotient bit per clock with a radix-2 restoring
// divider, then normalises and rounds (nearest, ties to even) in a single
// extra cycle. Subnormal operands are flushed to zero and results that fall
// below the normal range are returned as signed zero. Special operands
// (zero, inf, NaN) are resolved at accept time and skip the divider.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : a_in / b_in carry operands
//   in_ready   : block is idle and will accept operands
//   a_in       : dividend {sign, exp, man}
//   b_in       : divisor  {sign, exp, man}
//   out_valid  : c_out / flags hold a result
//   out_ready  : consumer takes the result
//   c_out      : quotient
//   flag_dz    : finite nonzero divided by zero
//   flag_inv   : invalid operation (0/0, inf/inf, NaN operand)
//
// Latency from the accepting edge: 1 cycle for special operands,
// MAN_W+5 cycles for normal operands.
// ---------------------------------------------------------------------------
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_in,
  input  logic [EXP_W+MAN_W:0]   b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c_out,
  output logic                   flag_dz,
  output logic                   flag_inv
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int SW  = MAN_W + 1;          // significand incl. hidden bit
  localparam int RW  = MAN_W + 2;          // partial remainder (< 2*divisor)
  localparam int QW  = MAN_W + 3;          // quotient bits: 1 int + MAN_W + guard + round
  localparam int EW2 = EXP_W + 2;          // signed working exponent
  localparam int CW  = $clog2(MAN_W + 3);

  localparam logic signed [EW2-1:0] BIAS   = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX   = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE    = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO   = '0;
  localparam logic [CW-1:0]         LAST   = CW'(MAN_W + 2);
  localparam logic [W-1:0]          QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [W-1:0]           c_q;
  logic                   dz_q;
  logic                   inv_q;
  logic                   sign_q;
  logic signed [EW2-1:0]  exp_q;
  logic [SW-1:0]          div_q;
  logic [RW-1:0]          rem_q;
  logic [QW-1:0]          quo_q;
  logic [CW-1:0]          cnt_q;

  // ---------------- operand fields and classification ----------------
  logic               a_sign, b_sign, res_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EW2-1:0] exp_acc;

  assign a_sign   = a_in[W-1];
  assign b_sign   = b_in[W-1];
  assign a_exp    = a_in[W-2:MAN_W];
  assign b_exp    = b_in[W-2:MAN_W];
  assign a_man    = a_in[MAN_W-1:0];
  assign b_man    = b_in[MAN_W-1:0];
  assign res_sign = a_sign ^ b_sign;

  // exp == 0 covers subnormals as well: they are treated as zero
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_man == '0);
  assign b_inf  = (&b_exp) && (b_man == '0);
  assign a_nan  = (&a_exp) && (a_man != '0);
  assign b_nan  = (&b_exp) && (b_man != '0);

  assign exp_acc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;

  // ---------------- special-case result ----------------
  logic          spec_hit;
  logic [W-1:0]  spec_c;
  logic          spec_dz;
  logic          spec_inv;

  always_comb begin
    spec_hit = 1'b1;
    spec_c   = '0;
    spec_dz  = 1'b0;
    spec_inv = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_c   = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_c = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      // a is finite and nonzero here
      spec_c  = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_c = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------- restoring division step ----------------
  // After a successful subtract the difference is below the divisor, so it
  // fits in SW bits and modular SW-bit subtraction gives the exact value.
  logic          div_ge;
  logic [SW-1:0] diff_lo;
  logic [SW-1:0] rem_sel;
  logic [RW-1:0] rem_d;
  logic [QW-1:0] quo_d;

  assign div_ge  = (rem_q >= {1'b0, div_q});
  assign diff_lo = rem_q[RW-2:0] - div_q;
  assign rem_sel = div_ge ? diff_lo : rem_q[RW-2:0];
  assign rem_d   = {rem_sel, 1'b0};
  assign quo_d   = {quo_q[QW-2:0], div_ge};

  // ---------------- normalise and round ----------------
  logic [SW-1:0]         sig;
  logic                  g_bit, r_bit, s_bit, rnd_inc;
  logic [SW:0]           sum;
  logic [MAN_W-1:0]      man_r;
  logic signed [EW2-1:0] e_n, e_r;
  logic [W-1:0]          norm_c;

  always_comb begin
    if (quo_q[QW-1]) begin
      sig   = quo_q[QW-1:2];
      g_bit = quo_q[1];
      r_bit = quo_q[0];
      e_n   = exp_q;
    end else begin
      // quotient below 1.0: shift left one place, round bit becomes 0
      sig   = quo_q[QW-2:1];
      g_bit = quo_q[0];
      r_bit = 1'b0;
      e_n   = exp_q - ONE;
    end
    s_bit   = |rem_q;
    rnd_inc = g_bit & (r_bit | s_bit | sig[0]);
    sum     = {1'b0, sig} + {{SW{1'b0}}, rnd_inc};
    // carry-out means the significand rounded up to 2.0
    e_r     = e_n + (sum[SW] ? ONE : ZERO);
    man_r   = sum[SW] ? sum[SW-1:1] : sum[MAN_W-1:0];
    if (e_r >= EMAX) begin
      norm_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r <= ZERO) begin
      norm_c = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_c = {sign_q, e_r[EXP_W-1:0], man_r};
    end
  end

  // ---------------- control FSM and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      dz_q        <= 1'b0;
      inv_q       <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= res_sign;
            exp_q      <= exp_acc;
            div_q      <= {1'b1, b_man};
            rem_q      <= {1'b0, 1'b1, a_man};
            quo_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (spec_hit) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              c_q         <= spec_c;
              dz_q        <= spec_dz;
              inv_q       <= spec_inv;
            end else begin
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          c_q         <= norm_c;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            dz_q        <= 1'b0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c_out     = c_q;
  assign flag_dz   = dz_q;
  assign flag_inv  = inv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_div_seq -- self-checking bench for fp_div_seq (single precision)
//
// Directed cases (exact, rounding, specials, overflow/underflow, output
// back-pressure, reset mid-division) followed by randomised operands. The
// reference model divides with wide integer arithmetic and rounds from the
// exact remainder.
// ---------------------------------------------------------------------------
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c_out;
  logic        flag_dz;
  logic        flag_inv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .flag_dz   (flag_dz),
    .flag_inv  (flag_inv)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: exact integer quotient with 26 fractional bits and remainder
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic dz,
                                  output logic inv, output logic is_spec);
    int          ea, eb, e, half;
    logic [22:0] fa, fb;
    logic        s, za, zb, ia, ib, na, nb, up;
    longint      ma, mb, num, q, r, sig, low;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    dz = 1'b0;
    inv = 1'b0;
    is_spec = 1'b1;
    c = 32'h0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      c = 32'h7FC00000;
      inv = 1'b1;
    end else if (ia) begin
      c = {s, 8'hFF, 23'h0};
    end else if (zb) begin
      c = {s, 8'hFF, 23'h0};
      dz = 1'b1;
    end else if (za || ib) begin
      c = {s, 31'h0};
    end else begin
      is_spec = 1'b0;
      ma  = 64'h800000 | longint'(fa);
      mb  = 64'h800000 | longint'(fb);
      num = ma << 26;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 26)) begin
        sig = q >> 3;  low = q & 7;  half = 4;
      end else begin
        sig = q >> 2;  low = q & 3;  half = 2;  e = e - 1;
      end
      up = (low > half) || ((low == half) && ((r != 0) || sig[0]));
      if (up) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
        sig = sig >> 1;
        e = e + 1;
      end
      if (e >= 255)     c = {s, 8'hFF, 23'h0};
      else if (e <= 0)  c = {s, 31'h0};
      else              c = {s, e[7:0], sig[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0:       return {1'($urandom), 8'h00, 23'($urandom)};          // zero / subnormal
      1:       return {1'($urandom), 8'hFF, 23'h0};                  // inf
      2:       return {1'($urandom), 8'hFF, 23'($urandom) | 23'h1};  // NaN
      default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Called on a negedge with the DUT idle; returns on a negedge with it idle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    logic [31:0] ec;
    logic        edz, einv, esp;
    int          lat, want_lat;
    ref_div(a, b, ec, edz, einv, esp);
    want_lat = esp ? 1 : 28;
    check_val({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(want_lat));
    check_val({tag, ".c_out"}, c_out, ec);
    check_val({tag, ".flag_dz"}, 32'(flag_dz), 32'(edz));
    check_val({tag, ".flag_inv"}, 32'(flag_inv), 32'(einv));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, ".hold_c"}, c_out, ec);
      check_val({tag, ".hold_flags"}, {30'd0, flag_dz, flag_inv}, {30'd0, edz, einv});
      check_val({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      // an operand offer while busy must be ignored
      a_in = 32'h3F800000;
      b_in = 32'h00000000;
      in_valid = (i >= 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, ".post_flags"}, {30'd0, flag_dz, flag_inv}, 32'd0);
    check_val({tag, ".post_c"}, c_out, ec);
    out_ready = 1'b0;
    $display("op %s: %h / %h -> %h dz=%0d inv=%0d lat=%0d", tag, a, b, ec, edz, einv, lat);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.c_out", c_out, 32'd0);
    check_val("rst.flags", {30'd0, flag_dz, flag_inv}, 32'd0);

    do_op(32'h40C00000, 32'h40000000, 0, "six_div_two");
    check_val("six_div_two.value", c_out, 32'h40400000);
    do_op(32'h3F800000, 32'h40400000, 0, "one_third");
    check_val("one_third.value", c_out, 32'h3EAAAAAB);
    do_op(32'h3F800000, 32'h00000000, 0, "div_by_zero");
    check_val("div_by_zero.value", c_out, 32'h7F800000);
    do_op(32'h00000000, 32'h80000000, 0, "zero_zero");
    check_val("zero_zero.value", c_out, 32'h7FC00000);
    do_op(32'h7F000000, 32'h00800000, 0, "overflow");
    check_val("overflow.value", c_out, 32'h7F800000);
    do_op(32'h00800000, 32'h7F000000, 0, "underflow");
    check_val("underflow.value", c_out, 32'h00000000);
    do_op(32'h40C00000, 32'h40000000, 10, "backpressure");

    // reset in the middle of a division
    a_in = 32'h40C00000;
    b_in = 32'h40000000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_val("midrst.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("midrst.in_ready", 32'(in_ready), 32'd1);
    check_val("midrst.c_out", c_out, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("midrst.no_result", 32'(seen), 32'd0);
    out_ready = 1'b0;
    do_op(32'h40C00000, 32'h40000000, 0, "after_reset");
    check_val("after_reset.value", c_out, 32'h40400000);

    for (int i = 0; i < 60; i++) begin
      do_op(rand_operand(), rand_operand(), ($urandom_range(0, 5) == 0) ? 3 : 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; word width W = EXP_W+MAN_W+1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands a_in/b_in present.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port a_in, input, W, dividend {sign, exp, man}.
REQ-008 SHALL have port b_in, input, W, divisor {sign, exp, man}.
REQ-009 SHALL have port out_valid, output, 1, c_out and flags hold a result.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 SHALL have port c_out, output, W, quotient a_in/b_in.
REQ-012 SHALL have port flag_dz, output, 1, finite nonzero / zero occurred.
REQ-013 SHALL have port flag_inv, output, 1, invalid operation (0/0, inf/inf, NaN operand).

Function
REQ-014 SHALL use FSM states IDLE, DIV, NORM, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL accept operands on an edge with in_valid & in_ready, registering a_in, b_in and sign = a_sign ^ b_sign.
REQ-016 SHALL classify operands at accept: exp = 0 means zero (subnormals flushed to zero); exp all-ones with man = 0 means inf; exp all-ones with man != 0 means NaN.
REQ-017 SHALL bypass DIV/NORM for special cases, going IDLE -> DONE with out_valid high 1 cycle after the accepting edge.
REQ-018 Special-case results SHALL be: any NaN, 0/0 or inf/inf -> canonical qNaN {0, all-ones, 1 followed by zeros}, flag_inv = 1; finite nonzero / 0 -> signed inf, flag_dz = 1; 0/x or x/inf -> signed zero; inf/x -> signed inf.
REQ-019 Normal operands SHALL go IDLE -> DIV and perform a radix-2 restoring division of {1,man_a} by {1,man_b}, producing one quotient bit per cycle for MAN_W+3 cycles, then a sticky bit = (remainder != 0).
REQ-020 NORM SHALL take 1 cycle: if the quotient MSB is 0, shift left 1 and decrement the exponent; then round to nearest, ties to even, using guard/round/sticky; a mantissa carry-out increments the exponent.
REQ-021 The exponent SHALL be computed in EXP_W+2 signed bits as exp_a - exp_b + (2^(EXP_W-1) - 1), with normalisation and rounding adjustments applied.
REQ-022 A final exponent >= all-ones SHALL give signed inf; a final exponent <= 0 SHALL give signed zero; no flag is raised for either.
REQ-023 Normal results SHALL assert out_valid exactly MAN_W+5 cycles after the accepting edge (28 for defaults).
REQ-024 In DONE, c_out, flag_dz and flag_inv SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-025 The transfer SHALL complete on an edge with out_valid & out_ready, going DONE -> IDLE; out_valid is 0 and in_ready is 1 the next cycle, with no same-cycle accept.
REQ-026 in_valid SHALL be ignored outside IDLE; exactly one operation is in flight at a time.
REQ-027 Outside DONE, flag_dz and flag_inv SHALL be 0; c_out keeps its last value.

Reset
REQ-028 rst_n = 0 at a rising edge SHALL force state IDLE, out_valid = 0, c_out = 0, flag_dz = 0, flag_inv = 0, and clear the quotient, remainder and counter; in_ready = 1 the cycle after reset.
REQ-029 Reset asserted during DIV, NORM or DONE SHALL abort the operation with no result ever presented for it.

Verification
REQ-030 The bench SHALL cover: a_in = 0x40C00000 (6.0), b_in = 0x40000000 (2.0), out_ready = 1 -> c_out = 0x40400000, flags 0, out_valid at cycle 28.
REQ-031 The bench SHALL cover: 0x3F800000 / 0x40400000 (1/3) -> c_out = 0x3EAAAAAB, checking RNE rounding up.
REQ-032 The bench SHALL cover: 0x3F800000 / 0x00000000 -> c_out = 0x7F800000, flag_dz = 1, out_valid at cycle 1; 0x00000000 / 0x80000000 -> c_out = 0x7FC00000, flag_inv = 1.
REQ-033 The bench SHALL cover: 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow); 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
REQ-034 The bench SHALL cover: out_ready held 0 for 10 cycles after out_valid -> c_out and flags stable, in_ready = 0, a new in_valid ignored; after out_ready = 1, in_ready = 1 on the next cycle.
REQ-035 The bench SHALL cover: rst_n = 0 for 1 cycle mid-DIV (cycle 10) -> out_valid stays 0, in_ready = 1 after reset, and the next 6.0/2.0 returns 0x40400000.
